gerenciador_servos_uc: RTL

Control unit for the three-servo manager (peteleco 360°, tampa 180°, base 180°). Consumes the one-cycle move requests and the 1 s timer `fim` flags produced by the servo datapath. Drives that datapath's counter clear/enable, T-flip-flop shift and continuous-rotation `gira` signals, and reports `ocupado`/`pronto` to the cube-solver sequencer. Executes one servo movement at a time. Requests are recorded in pending flags and served in fixed priority.

---
 rtl/gerenciador_servos_uc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gerenciador_servos_uc.sv
// gerenciador_servos_uc
// Control unit for the three-servo manager (peteleco 360 deg, tampa 180 deg,
// base 180 deg). Serves one movement at a time; requests are latched in
// pending flags and served with priority peteleco > tampa > base.
//
// Ports:
//   clock, reset                      : 50 MHz clock, async active-high reset
//   move_servo_{peteleco,tampa,base}  : one-cycle move request pulses
//   fim_servo_{peteleco,tampa,base}   : timer terminal-count flags
//   zera_servo_*                      : timer clear
//   conta_servo_*                     : timer enable
//   gira                              : peteleco rotates while high
//   shifta_servo_{tampa,base}         : one-cycle toggle of position flip-flop
//   ocupado, pronto                   : busy level / completion pulse
//   db_estado                         : current state code
//
// Build option: GERENCIADOR_FILA_EN -- when defined, requests arriving while
// busy are queued (one per servo); otherwise they are only accepted in OCIOSO.
//
// state     | meaning
// INICIAL   | after reset, clear all timers
// OCIOSO    | idle, waiting for a pending request
// ZERA_P    | clear peteleco timer
// ESPERA_P  | peteleco rotating, wait for its timer
// ZERA_T    | clear tampa timer
// SHIFT_T   | toggle tampa position
// ESPERA_T  | wait tampa timer
// ZERA_B    | clear base timer
// SHIFT_B   | toggle base position
// ESPERA_B  | wait base timer
// FIM       | movement done, pulse pronto

module gerenciador_servos_uc (
    input  logic       clock,
    input  logic       reset,
    input  logic       move_servo_peteleco,
    input  logic       move_servo_tampa,
    input  logic       move_servo_base,
    input  logic       fim_servo_peteleco,
    input  logic       fim_servo_tampa,
    input  logic       fim_servo_base,
    output logic       zera_servo_peteleco,
    output logic       zera_servo_tampa,
    output logic       zera_servo_base,
    output logic       conta_servo_peteleco,
    output logic       conta_servo_tampa,
    output logic       conta_servo_base,
    output logic       gira,
    output logic       shifta_servo_tampa,
    output logic       shifta_servo_base,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        OCIOSO   = 4'd1,
        ZERA_P   = 4'd2,
        ESPERA_P = 4'd3,
        ZERA_T   = 4'd4,
        SHIFT_T  = 4'd5,
        ESPERA_T = 4'd6,
        ZERA_B   = 4'd7,
        SHIFT_B  = 4'd8,
        ESPERA_B = 4'd9,
        FIM      = 4'd10
    } estado_t;

    estado_t estado, estado_prox;
    logic    pend_p, pend_t, pend_b;
    logic    pend_p_prox, pend_t_prox, pend_b_prox;
    logic    set_en;

    always_comb begin
        estado_prox = INICIAL;
        case (estado)
            INICIAL:  estado_prox = OCIOSO;
            OCIOSO: begin
                if (pend_p)      estado_prox = ZERA_P;
                else if (pend_t) estado_prox = ZERA_T;
                else if (pend_b) estado_prox = ZERA_B;
                else             estado_prox = OCIOSO;
            end
            ZERA_P:   estado_prox = ESPERA_P;
            ESPERA_P: estado_prox = fim_servo_peteleco ? FIM : ESPERA_P;
            ZERA_T:   estado_prox = SHIFT_T;
            SHIFT_T:  estado_prox = ESPERA_T;
            ESPERA_T: estado_prox = fim_servo_tampa ? FIM : ESPERA_T;
            ZERA_B:   estado_prox = SHIFT_B;
            SHIFT_B:  estado_prox = ESPERA_B;
            ESPERA_B: estado_prox = fim_servo_base ? FIM : ESPERA_B;
            FIM:      estado_prox = OCIOSO;
            default:  estado_prox = INICIAL;
        endcase
    end

`ifdef GERENCIADOR_FILA_EN
    assign set_en = 1'b1;
`else
    assign set_en = (estado == OCIOSO);
`endif

    // Clear happens on the OCIOSO -> ZERA_x edge; a new pulse on that same
    // edge is OR-ed in afterwards so the servo runs again.
    always_comb begin
        pend_p_prox = (pend_p & ~(estado == OCIOSO && estado_prox == ZERA_P))
                    | (move_servo_peteleco & set_en);
        pend_t_prox = (pend_t & ~(estado == OCIOSO && estado_prox == ZERA_T))
                    | (move_servo_tampa & set_en);
        pend_b_prox = (pend_b & ~(estado == OCIOSO && estado_prox == ZERA_B))
                    | (move_servo_base & set_en);
    end

    // Outputs are registered from the next state so they line up with estado.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado               <= INICIAL;
            pend_p               <= 1'b0;
            pend_t               <= 1'b0;
            pend_b               <= 1'b0;
            zera_servo_peteleco  <= 1'b1;
            zera_servo_tampa     <= 1'b1;
            zera_servo_base      <= 1'b1;
            conta_servo_peteleco <= 1'b0;
            conta_servo_tampa    <= 1'b0;
            conta_servo_base     <= 1'b0;
            gira                 <= 1'b0;
            shifta_servo_tampa   <= 1'b0;
            shifta_servo_base    <= 1'b0;
            ocupado              <= 1'b1;
            pronto               <= 1'b0;
        end else begin
            estado               <= estado_prox;
            pend_p               <= pend_p_prox;
            pend_t               <= pend_t_prox;
            pend_b               <= pend_b_prox;
            zera_servo_peteleco  <= (estado_prox == INICIAL) || (estado_prox == ZERA_P);
            zera_servo_tampa     <= (estado_prox == INICIAL) || (estado_prox == ZERA_T);
            zera_servo_base      <= (estado_prox == INICIAL) || (estado_prox == ZERA_B);
            conta_servo_peteleco <= (estado_prox == ESPERA_P);
            conta_servo_tampa    <= (estado_prox == ESPERA_T);
            conta_servo_base     <= (estado_prox == ESPERA_B);
            gira                 <= (estado_prox == ESPERA_P);
            shifta_servo_tampa   <= (estado_prox == SHIFT_T);
            shifta_servo_base    <= (estado_prox == SHIFT_B);
            ocupado              <= (estado_prox != OCIOSO);
            pronto               <= (estado_prox == FIM);
        end
    end

    assign db_estado = estado;

endmodule
